// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the LCD init sequencer.
// Also holds the init ROM and the DDRAM address helper.
package lcd_pkg;

  typedef enum logic [3:0] {
    StPwrWait,
    StInitSend,
    StInitWait,
    StIdle,
    StAddrSend,
    StAddrWait,
    StCharSend,
    StCharWait,
    StClrSend,
    StClrWait
  } lcd_state_e;

  localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LINE2_BASE    = 8'h40;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    unique case (idx)
      2'd0:    init_rom = CMD_FUNC_SET;
      2'd1:    init_rom = CMD_DISP_ON;
      2'd2:    init_rom = CMD_ENTRY;
      default: init_rom = CMD_CLEAR;
    endcase
  endfunction

  // Positions 16..31 live at DDRAM 0x40.. on the second line.
  function automatic logic [7:0] ddram_cmd(input logic [4:0] pos);
    logic [7:0] addr;
    addr = {4'h0, pos[3:0]};
    if (pos[4]) addr = addr | LINE2_BASE;
    ddram_cmd = CMD_SET_DDRAM | addr;
  endfunction

endpackage

// File: rtl/lcd_init_sequencer_if.sv
// Upstream character/clear request port of the LCD init sequencer.
interface lcd_init_sequencer_if;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] char_data;
  logic [4:0] char_pos;
  logic       clear_req;

  modport master (
    output char_valid, char_data, char_pos, clear_req,
    input  char_ready
  );

  modport slave (
    input  char_valid, char_data, char_pos, clear_req,
    output char_ready
  );
endinterface

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module lcd_delay_timer #(
  parameter int unsigned     Width    = 8,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             done
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= ResetVal;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_init_sequencer.sv
// HD44780 power-on init, then serialises char writes and clears into timed lcd_send strobes.
module lcd_init_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES    = 750_000,
  parameter int unsigned CMD_WAIT_CYCLES   = 2_500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 82_000
) (
  input  logic                       clk,
  input  logic                       rst,
  lcd_init_sequencer_if.slave        char_if,
  output logic                       init_done,
  output logic                       busy,
  output logic [7:0]                 lcd_data_in,
  output logic                       rs_select,
  output logic                       lcd_send
);

  localparam int unsigned MaxWait =
      (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ?
      ((POWERUP_CYCLES > CMD_WAIT_CYCLES) ? POWERUP_CYCLES : CMD_WAIT_CYCLES) :
      ((CLEAR_WAIT_CYCLES > CMD_WAIT_CYCLES) ? CLEAR_WAIT_CYCLES : CMD_WAIT_CYCLES);
  localparam int unsigned CntW = $clog2(MaxWait);

  // Loaded during the send cycle; the wait state then lasts W-1 cycles so the next
  // send lands exactly W cycles after the previous one.
  localparam logic [CntW-1:0] CmdLoad = CntW'(CMD_WAIT_CYCLES - 2);
  localparam logic [CntW-1:0] ClrLoad = CntW'(CLEAR_WAIT_CYCLES - 2);
  localparam logic [CntW-1:0] PwrLoad = CntW'(POWERUP_CYCLES - 1);

  lcd_state_e      state_q, state_d;
  logic [1:0]      init_idx_q, init_idx_d;
  logic            init_done_q, init_done_d;
  logic [7:0]      data_q, data_d;
  logic            rs_q, rs_d;
  logic [4:0]      cur_pos_q, cur_pos_d;
  logic            cur_valid_q, cur_valid_d;
  logic [7:0]      char_q, char_d;
  logic [4:0]      pos_q, pos_d;
  logic            tmr_load;
  logic [CntW-1:0] tmr_val;
  logic            tmr_done;

  lcd_delay_timer #(
    .Width    (CntW),
    .ResetVal (PwrLoad)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPwrWait;
      init_idx_q  <= 2'd0;
      init_done_q <= 1'b0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      cur_pos_q   <= 5'd0;
      cur_valid_q <= 1'b0;
      char_q      <= 8'h00;
      pos_q       <= 5'd0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      cur_pos_q   <= cur_pos_d;
      cur_valid_q <= cur_valid_d;
      char_q      <= char_d;
      pos_q       <= pos_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    data_d      = data_q;
    rs_d        = rs_q;
    cur_pos_d   = cur_pos_q;
    cur_valid_d = cur_valid_q;
    char_d      = char_q;
    pos_d       = pos_q;
    tmr_load    = 1'b0;
    tmr_val     = CmdLoad;
    unique case (state_q)
      StPwrWait: if (tmr_done) begin
        state_d = StInitSend;
        data_d  = init_rom(init_idx_q);
        rs_d    = 1'b0;
      end
      StInitSend: begin
        tmr_load = 1'b1;
        state_d  = StInitWait;
        if (init_idx_q == 2'd3) begin
          tmr_val     = ClrLoad;
          cur_pos_d   = 5'd0;
          cur_valid_d = 1'b1;
        end
      end
      StInitWait: if (tmr_done) begin
        if (init_idx_q == 2'd3) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end else begin
          init_idx_d = init_idx_q + 2'd1;
          state_d    = StInitSend;
          data_d     = init_rom(init_idx_q + 2'd1);
          rs_d       = 1'b0;
        end
      end
      StIdle: begin
        if (char_if.clear_req) begin
          state_d = StClrSend;
          data_d  = CMD_CLEAR;
          rs_d    = 1'b0;
        end else if (char_if.char_valid) begin
          char_d = char_if.char_data;
          pos_d  = char_if.char_pos;
          if (cur_valid_q && (char_if.char_pos == cur_pos_q)) begin
            state_d = StCharSend;
            data_d  = char_if.char_data;
            rs_d    = 1'b1;
          end else begin
            state_d = StAddrSend;
            data_d  = ddram_cmd(char_if.char_pos);
            rs_d    = 1'b0;
          end
        end
      end
      StAddrSend: begin
        tmr_load = 1'b1;
        state_d  = StAddrWait;
      end
      StAddrWait: if (tmr_done) begin
        state_d = StCharSend;
        data_d  = char_q;
        rs_d    = 1'b1;
      end
      StCharSend: begin
        tmr_load    = 1'b1;
        state_d     = StCharWait;
        cur_pos_d   = pos_q + 5'd1;
        // The controller does not wrap from the end of a line to the next one.
        cur_valid_d = (pos_q[3:0] != 4'hF);
      end
      StCharWait: if (tmr_done) state_d = StIdle;
      StClrSend: begin
        tmr_load    = 1'b1;
        tmr_val     = ClrLoad;
        state_d     = StClrWait;
        cur_pos_d   = 5'd0;
        cur_valid_d = 1'b1;
      end
      StClrWait: if (tmr_done) state_d = StIdle;
      default: state_d = StPwrWait;
    endcase
  end

  assign char_if.char_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign init_done   = init_done_q;
  assign lcd_data_in = data_q;
  assign rs_select   = rs_q;
  assign lcd_send    = (state_q == StInitSend) || (state_q == StAddrSend) ||
                       (state_q == StCharSend) || (state_q == StClrSend);

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Directed bench for lcd_init_sequencer with shortened delays (100/30/80 cycles).
module tb_lcd_init_sequencer;

  logic       clk;
  logic       rst;
  logic       init_done;
  logic       busy;
  logic [7:0] lcd_data_in;
  logic       rs_select;
  logic       lcd_send;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int strobes     = 0;
  int snap        = 0;

  lcd_init_sequencer_if cif ();

  lcd_init_sequencer #(
    .POWERUP_CYCLES    (100),
    .CMD_WAIT_CYCLES   (30),
    .CLEAR_WAIT_CYCLES (80)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .char_if     (cif),
    .init_done   (init_done),
    .busy        (busy),
    .lcd_data_in (lcd_data_in),
    .rs_select   (rs_select),
    .lcd_send    (lcd_send)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (lcd_send === 1'b1) strobes++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Move to 1 time unit after rising edge number c (counted from reset release).
  task automatic to_cycle(input int c);
    repeat (c - cyc) @(posedge clk);
    cyc = c;
    #1;
  endtask

  task automatic chk_strobe(input string tag, input logic [7:0] d, input logic rs);
    chk({tag, "_send"}, {31'd0, lcd_send}, 32'd1);
    chk({tag, "_data"}, {24'd0, lcd_data_in}, {24'd0, d});
    chk({tag, "_rs"}, {31'd0, rs_select}, {31'd0, rs});
  endtask

  task automatic req_char(input logic [7:0] d, input logic [4:0] p);
    cif.char_valid = 1'b1;
    cif.char_data  = d;
    cif.char_pos   = p;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  int          init_t[4] = '{100, 130, 160, 190};
  logic [7:0]  init_d[4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  initial begin
    rst            = 1'b1;
    cif.char_valid = 1'b0;
    cif.char_data  = 8'h00;
    cif.char_pos   = 5'd0;
    cif.clear_req  = 1'b0;
    repeat (3) @(posedge clk);
    release_reset();

    // 1: power-up wait and init ROM
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_send", {31'd0, lcd_send}, 32'd0);
    chk("rst_data", {24'd0, lcd_data_in}, 32'd0);
    chk("rst_ready", {31'd0, cif.char_ready}, 32'd0);
    chk("rst_done", {31'd0, init_done}, 32'd0);
    to_cycle(99);
    chk("pwr_early", {31'd0, lcd_send}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      to_cycle(init_t[i]);
      chk_strobe($sformatf("init%0d", i), init_d[i], 1'b0);
      to_cycle(init_t[i] + 1);
      chk($sformatf("init%0d_pulse", i), {31'd0, lcd_send}, 32'd0);
    end
    to_cycle(269);
    chk("init_ready_early", {31'd0, cif.char_ready}, 32'd0);
    chk("init_done_early", {31'd0, init_done}, 32'd0);
    to_cycle(270);
    chk("init_done", {31'd0, init_done}, 32'd1);
    chk("init_ready", {31'd0, cif.char_ready}, 32'd1);
    chk("init_busy", {31'd0, busy}, 32'd0);
    chk("init_count", strobes, 32'd4);

    // 2: pos 0 after clear, no address strobe
    snap = strobes;
    req_char(8'h54, 5'd0);
    to_cycle(271);
    cif.char_valid = 1'b0;
    cif.char_data  = 8'hFF;
    chk_strobe("c54", 8'h54, 1'b1);
    chk("c54_ready", {31'd0, cif.char_ready}, 32'd0);
    to_cycle(300);
    chk("c54_ready_low", {31'd0, cif.char_ready}, 32'd0);
    chk("c54_held", {24'd0, lcd_data_in}, 32'h54);
    to_cycle(301);
    chk("c54_ready_back", {31'd0, cif.char_ready}, 32'd1);
    chk("c54_count", strobes - snap, 32'd1);

    // 3: pos 17 needs address, then pos 18 follows on
    req_char(8'h41, 5'd17);
    to_cycle(302);
    cif.char_valid = 1'b0;
    cif.char_pos   = 5'd0;
    chk_strobe("a17", 8'hC1, 1'b0);
    to_cycle(331);
    chk("a17_gap", {31'd0, lcd_send}, 32'd0);
    to_cycle(332);
    chk_strobe("c41", 8'h41, 1'b1);
    to_cycle(361);
    chk("c41_ready_low", {31'd0, cif.char_ready}, 32'd0);
    to_cycle(362);
    chk("c41_ready", {31'd0, cif.char_ready}, 32'd1);
    snap = strobes;
    req_char(8'h42, 5'd18);
    to_cycle(363);
    cif.char_valid = 1'b0;
    chk_strobe("c42", 8'h42, 1'b1);
    to_cycle(393);
    chk("c42_ready", {31'd0, cif.char_ready}, 32'd1);
    chk("c42_count", strobes - snap, 32'd1);

    // 4: pos 15 then pos 16 must re-address
    req_char(8'h5A, 5'd15);
    to_cycle(394);
    cif.char_valid = 1'b0;
    chk_strobe("a15", 8'h8F, 1'b0);
    to_cycle(424);
    chk_strobe("c5a", 8'h5A, 1'b1);
    to_cycle(454);
    chk("c5a_ready", {31'd0, cif.char_ready}, 32'd1);
    req_char(8'h5B, 5'd16);
    to_cycle(455);
    cif.char_valid = 1'b0;
    chk_strobe("a16", 8'hC0, 1'b0);
    to_cycle(485);
    chk_strobe("c5b", 8'h5B, 1'b1);
    to_cycle(515);
    chk("c5b_ready", {31'd0, cif.char_ready}, 32'd1);

    // 5: clear beats a simultaneous char request
    req_char(8'h30, 5'd0);
    cif.clear_req = 1'b1;
    to_cycle(516);
    cif.clear_req = 1'b0;
    chk_strobe("clr", 8'h01, 1'b0);
    chk("clr_ready", {31'd0, cif.char_ready}, 32'd0);
    to_cycle(595);
    chk("clr_ready_low", {31'd0, cif.char_ready}, 32'd0);
    chk("clr_held", {24'd0, lcd_data_in}, 32'h01);
    to_cycle(596);
    chk("clr_ready_back", {31'd0, cif.char_ready}, 32'd1);
    chk("clr_nosend", {31'd0, lcd_send}, 32'd0);
    to_cycle(597);
    cif.char_valid = 1'b0;
    chk_strobe("c30", 8'h30, 1'b1);
    to_cycle(627);
    chk("c30_ready", {31'd0, cif.char_ready}, 32'd1);

    // 6: reset during CHAR_WAIT
    req_char(8'h31, 5'd1);
    to_cycle(628);
    cif.char_valid = 1'b0;
    chk_strobe("c31", 8'h31, 1'b1);
    to_cycle(640);
    rst = 1'b1;
    #1;
    chk("mid_send", {31'd0, lcd_send}, 32'd0);
    chk("mid_data", {24'd0, lcd_data_in}, 32'd0);
    chk("mid_rs", {31'd0, rs_select}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_done", {31'd0, init_done}, 32'd0);
    chk("mid_ready", {31'd0, cif.char_ready}, 32'd0);
    repeat (2) @(posedge clk);
    release_reset();
    to_cycle(99);
    chk("re_early", {31'd0, lcd_send}, 32'd0);
    to_cycle(100);
    chk_strobe("re_init0", 8'h38, 1'b0);
    to_cycle(130);
    chk_strobe("re_init1", 8'h0C, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_init_sequencer.md
# lcd_init_sequencer

Controller that sequences the `lcd_driver` block. It performs the HD44780 power-on initialisation, then serialises character-write and clear requests from the display-formatting logic into timed `lcd_send` strobes. It sits between the sensor formatting logic and `lcd_driver`. It enforces LCD execution delays, so upstream logic only sees a ready/valid character port.

## Interface
- `POWERUP_CYCLES`, 750_000: wait after reset before the first command (15 ms at 50 MHz).
- `CMD_WAIT_CYCLES`, 2_500: spacing between consecutive sends (50 µs). Must be greater than 25, the `lcd_driver` EN pulse length.
- `CLEAR_WAIT_CYCLES`, 82_000: spacing after a 0x01 command (1.64 ms).
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `char_valid`  in  1  upstream character request.
- `char_ready`  out  1  high only in IDLE; a request is accepted when `char_valid` and `char_ready` are both high.
- `char_data`  in  8  ASCII code.
- `char_pos`  in  5  screen position: 0–15 is line 1, 16–31 is line 2.
- `clear_req`  in  1  level request for a clear display; sampled only in IDLE.
- `init_done`  out  1  rises once the init sequence completes; stays high until reset.
- `busy`  out  1  high whenever the state is not IDLE.
- `lcd_data_in`  out  8  to `lcd_driver`.
- `rs_select`  out  1  to `lcd_driver`: 0 = command, 1 = data.
- `lcd_send`  out  1  to `lcd_driver`: one-cycle strobe.

## Operation
- **States:** PWR_WAIT → INIT_SEND → INIT_WAIT (repeat 4×) → IDLE; IDLE → ADDR_SEND → ADDR_WAIT → CHAR_SEND → CHAR_WAIT → IDLE; IDLE → CLR_SEND → CLR_WAIT → IDLE.
- **Init ROM:** index 0..3 = 0x38, 0x0C, 0x06, 0x01, all sent with RS=0.
  - Indices 0–2 use `CMD_WAIT_CYCLES`; index 3 uses `CLEAR_WAIT_CYCLES`.
  - `init_done` is set on the transition INIT_WAIT(3) → IDLE.
- **Address mapping:** `pos` < 16 → DDRAM 0x00+pos; `pos` ≥ 16 → 0x40+(pos−16). The command sent is 0x80 | addr.
- **Cursor tracking:** a register `cur_pos[4:0]` plus a `cur_valid` flag.
  - ADDR_SEND is skipped (IDLE → CHAR_SEND) when `cur_valid` is set and `char_pos` == `cur_pos`.
  - After each CHAR_SEND: `cur_pos` ← `pos`+1. `cur_valid` is cleared if `pos` == 15 or `pos` == 31 (hardware does not wrap to the next line); otherwise it is set.
  - Clear (init or request) sets `cur_pos`=0 and `cur_valid`=1.
- `char_data` and `char_pos` are latched on acceptance. Upstream may change them afterwards.
- **Priority in IDLE:** `clear_req` wins over `char_valid` when both are high; the character request stays pending with `char_ready` low.
- `lcd_data_in` and `rs_select` are registered. They are updated in the same cycle as `lcd_send` and held until the next send.
- **Reset (including mid-sequence):**
  - All outputs go to 0, except `busy`=1.
  - State → PWR_WAIT, `cur_valid`=0, `init_done`=0.
  - The full power-up wait and init sequence rerun.

## Timing
- The first `lcd_send` is asserted `POWERUP_CYCLES` rising edges after `rst` deasserts.
- A send asserted in cycle P is followed by the next send no earlier than cycle P+W, where W is the wait for the previous command. The wait counter loads in the cycle after P.
- **Accept → first strobe:** a request accepted at edge T produces its first `lcd_send` in cycle T+1.
  - Address skipped: one strobe; `char_ready` returns in cycle T+1+CMD_WAIT.
  - Address needed: second strobe at T+1+CMD_WAIT; `char_ready` returns at T+1+2·CMD_WAIT.
- **Clear:** strobe at T+1; `char_ready` returns at T+1+CLEAR_WAIT.
- `char_ready` is combinational from state (IDLE) and is never asserted before `init_done`.
- Counters are `$clog2(max wait)` bits wide. They never wrap; the count is reloaded on every state entry.

## Structure
- Package `lcd_pkg` holds:
  - the state enum;
  - command constants CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY=0x06, CMD_CLEAR=0x01, CMD_SET_DDRAM=0x80, LINE2_BASE=0x40;
  - the init-ROM function.
- One sub-module, `lcd_delay_timer`: load/count-down with a `done` flag, shared by all wait states.

## Test plan
Bench parameters: POWERUP=100, CMD_WAIT=30, CLEAR_WAIT=80.
1. Release reset and count cycles → strobes at cycles 100, 130, 160, 190 with data 0x38, 0x0C, 0x06, 0x01 and RS=0; `init_done`=1 and `char_ready`=1 at cycle 270.
2. After init, send char 0x54 at pos 0 → single RS=1 strobe with data 0x54 (no address strobe); `char_ready` low for 30 cycles.
3. Send char 0x41 at pos 17 → strobe 0x C1 with RS=0, then 30 cycles later 0x41 with RS=1. Follow with pos 18 → data strobe only.
4. Write pos 15, then pos 16 → second write issues address 0xC0 because cursor tracking was invalidated.
5. Raise `clear_req` and `char_valid` in the same IDLE cycle → 0x01 strobe first; character accepted 80 cycles later; it is sent without an address if pos=0.
6. Assert `rst` during CHAR_WAIT → outputs zero immediately, `busy`=1; the init sequence restarts 100 cycles after release.
